ahb_bus_arbiter: RTL and testbench

Round-robin AHB bus arbiter for the multi-master interconnect. It takes per-master bus requests and lock requests, plus the transfer-control signals of the currently muxed master. It drives one-hot HGRANT, the address-phase owner index HMASTER and HMASTLOCK to the address/data muxes and slave decoders. Fixed-length bursts and locked sequences are never split; the grant moves only on HREADY-high edges.

---
 rtl/ahb_bus_arbiter.sv | 137 +++++++++++++
 tb/tb_ahb_bus_arbiter.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/ahb_bus_arbiter.sv
// ahb_bus_arbiter
//   Round-robin AHB bus arbiter. Grants the bus to one master at a time.
//   Fixed-length bursts and locked sequences are never split, and the grant
//   moves only on edges where HREADY is high.
//
// Ports
//   HCLK      in   bus clock; all state changes on the rising edge
//   HRESET    in   asynchronous active-high reset
//   HBUSREQ   in   per-master bus request
//   HLOCK     in   per-master locked-transfer request
//   HTRANS    in   transfer type of the muxed owner (IDLE/BUSY/NONSEQ/SEQ)
//   HBURST    in   burst type of the muxed owner (SINGLE..INCR16)
//   HREADY    in   slave ready; the transfer is accepted when high
//   HGRANT    out  one-hot grant (registered)
//   HMASTER   out  index of the master owning the current address phase
//   HMASTLOCK out  the current address phase is locked
module ahb_bus_arbiter #(
  parameter int unsigned MASTERS        = 9,
  parameter int unsigned DEFAULT_MASTER = 0,
  parameter int unsigned MW             = (MASTERS > 1) ? $clog2(MASTERS) : 1
) (
  input  logic               HCLK,
  input  logic               HRESET,
  input  logic [MASTERS-1:0] HBUSREQ,
  input  logic [MASTERS-1:0] HLOCK,
  input  logic [1:0]         HTRANS,
  input  logic [2:0]         HBURST,
  input  logic               HREADY,
  output logic [MASTERS-1:0] HGRANT,
  output logic [MW-1:0]      HMASTER,
  output logic               HMASTLOCK
);

  localparam logic [1:0] ST_ARB   = 2'd0;
  localparam logic [1:0] ST_BURST = 2'd1;
  localparam logic [1:0] ST_LOCK  = 2'd2;

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_BUSY   = 2'b01;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;

  localparam logic [MASTERS-1:0] LP_DEF_OH =
    {{(MASTERS-1){1'b0}}, 1'b1} << DEFAULT_MASTER;
  localparam logic [MW-1:0] LP_DEF_IDX = MW'(DEFAULT_MASTER);

  logic [MASTERS-1:0] r_grant;
  logic [MW-1:0]      r_rr;       // index of the currently granted master
  logic [MW-1:0]      r_master;
  logic               r_mastlock;
  logic [3:0]         r_cnt;

  logic [3:0]         w_cnt_next;
  logic [1:0]         w_state;
  logic [MW-1:0]      w_next_idx;
  logic               w_found;
  logic [MASTERS-1:0] w_next_oh;

  // Beat counter value taken at this edge; frozen while HREADY is low.
  always_comb begin
    w_cnt_next = r_cnt;
    if (HREADY) begin
      case (HTRANS)
        TR_NONSEQ: begin
          case (HBURST)
            3'd2, 3'd3: w_cnt_next = 4'd3;
            3'd4, 3'd5: w_cnt_next = 4'd7;
            3'd6, 3'd7: w_cnt_next = 4'd15;
            default:    w_cnt_next = 4'd0;
          endcase
        end
        TR_SEQ:  w_cnt_next = (r_cnt != 4'd0) ? r_cnt - 4'd1 : r_cnt;
        TR_IDLE: w_cnt_next = 4'd0;
        TR_BUSY: w_cnt_next = r_cnt;
        default: w_cnt_next = r_cnt;
      endcase
    end
  end

  // Lock of the granted master dominates; an unfinished fixed burst blocks
  // regrant because the counter only reaches zero on the final beat's edge.
  always_comb begin
    if (HLOCK[r_rr])
      w_state = ST_LOCK;
    else if (w_cnt_next != 4'd0)
      w_state = ST_BURST;
    else
      w_state = ST_ARB;
  end

  // Search rr+1 .. rr (wrapping), so the current owner has lowest priority.
  always_comb begin
    int unsigned v_sum;
    logic [MW-1:0] v_idx;
    w_next_idx = LP_DEF_IDX;
    w_found    = 1'b0;
    for (int unsigned i = 1; i <= MASTERS; i++) begin
      v_sum = int'(r_rr) + i;
      if (v_sum >= MASTERS)
        v_sum = v_sum - MASTERS;
      v_idx = MW'(v_sum);
      if (!w_found && HBUSREQ[v_idx]) begin
        w_found    = 1'b1;
        w_next_idx = v_idx;
      end
    end
  end

  always_comb begin
    w_next_oh             = '0;
    w_next_oh[w_next_idx] = 1'b1;
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_grant    <= LP_DEF_OH;
      r_rr       <= LP_DEF_IDX;
      r_master   <= LP_DEF_IDX;
      r_mastlock <= 1'b0;
      r_cnt      <= '0;
    end else if (HREADY) begin
      r_cnt      <= w_cnt_next;
      // Address-phase ownership follows the grant held before this edge.
      r_master   <= r_rr;
      r_mastlock <= HLOCK[r_rr];
      if (w_state == ST_ARB) begin
        r_rr    <= w_next_idx;
        r_grant <= w_next_oh;
      end
    end
  end

  assign HGRANT    = r_grant;
  assign HMASTER   = r_master;
  assign HMASTLOCK = r_mastlock;

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// tb_ahb_bus_arbiter
//   Directed-vector bench for ahb_bus_arbiter (9 masters, default master 0).
module tb_ahb_bus_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [8:0] req;
  logic [8:0] lock;
  logic [1:0] trans;
  logic [2:0] burst;
  logic       ready;
  logic [8:0] grant;
  logic [3:0] master;
  logic       mlock;

  int n_total = 0;
  int n_bad   = 0;

  localparam logic [1:0] IDLE = 2'b00, BUSY = 2'b01, NONSEQ = 2'b10, SEQ = 2'b11;
  localparam logic [2:0] SINGLE = 3'd0, INCR4 = 3'd3, INCR16 = 3'd7;

  always #5 clk = ~clk;

  ahb_bus_arbiter #(
    .MASTERS        (9),
    .DEFAULT_MASTER (0)
  ) dut (
    .HCLK      (clk),
    .HRESET    (rst),
    .HBUSREQ   (req),
    .HLOCK     (lock),
    .HTRANS    (trans),
    .HBURST    (burst),
    .HREADY    (ready),
    .HGRANT    (grant),
    .HMASTER   (master),
    .HMASTLOCK (mlock)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [8:0] rr_g [5];
  logic [3:0] rr_m [5];

  initial begin
    rst = 1'b1; req = '0; lock = '0; trans = IDLE; burst = SINGLE; ready = 1'b1;

    // reset state
    tick(); tick();
    chk("rst_grant", grant, 9'h001);
    chk("rst_master", master, 4'd0);
    chk("rst_lock", mlock, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_grant", grant, 9'h001);
      chk("idle_master", master, 4'd0);
      chk("idle_lock", mlock, 1'b0);
    end

    // round robin among 2, 5, 7
    rr_g = '{9'h004, 9'h020, 9'h080, 9'h004, 9'h020};
    rr_m = '{4'd0, 4'd2, 4'd5, 4'd7, 4'd2};
    req = 9'h0A4; trans = NONSEQ; burst = SINGLE;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rr_grant", grant, rr_g[i]);
      chk("rr_master", master, rr_m[i]);
    end

    // give the bus to master 3
    req = 9'h008; trans = IDLE;
    tick(); chk("own3_grant", grant, 9'h008);
    tick(); chk("own3_master", master, 4'd3);

    // INCR4 by master 3 with master 4 waiting
    req = 9'h018; trans = NONSEQ; burst = INCR4;
    tick(); chk("b4_beat1", grant, 9'h008);
    trans = SEQ;
    tick(); chk("b4_beat2", grant, 9'h008);
    tick(); chk("b4_beat3", grant, 9'h008);
    tick(); chk("b4_beat4_handover", grant, 9'h010);
    chk("b4_master_old", master, 4'd3);
    req = 9'h010; trans = IDLE;
    tick(); chk("b4_master_new", master, 4'd4);
    chk("b4_grant_keep", grant, 9'h010);

    // INCR4 by master 4, 2-cycle stall on beat 2, master 3 waiting
    req = 9'h018; trans = NONSEQ; burst = INCR4;
    tick(); chk("st_beat1", grant, 9'h010);
    trans = SEQ; ready = 1'b0;
    tick(); chk("st_stall1", grant, 9'h010);
    tick(); chk("st_stall2", grant, 9'h010);
    chk("st_stall_master", master, 4'd4);
    ready = 1'b1;
    tick(); chk("st_beat2", grant, 9'h010);
    tick(); chk("st_beat3", grant, 9'h010);
    tick(); chk("st_beat4_handover", grant, 9'h008);
    req = 9'h008; trans = IDLE;
    tick(); chk("st_master_new", master, 4'd3);

    // locked sequence by master 1 while master 6 requests
    req = 9'h002;
    tick(); chk("lk_grant1", grant, 9'h002);
    req = 9'h042; lock = 9'h002; trans = NONSEQ; burst = SINGLE;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("lk_grant_hold", grant, 9'h002);
      chk("lk_master", master, 4'd1);
      chk("lk_mastlock", mlock, 1'b1);
    end
    lock = '0; trans = IDLE;
    tick();
    chk("lk_release_grant", grant, 9'h040);
    chk("lk_release_lock", mlock, 1'b0);

    // master 8 in INCR16, reset at cnt=9
    req = 9'h100;
    tick(); chk("r8_grant", grant, 9'h100);
    tick(); chk("r8_master", master, 4'd8);
    trans = NONSEQ; burst = INCR16;
    tick();
    trans = SEQ;
    for (int i = 0; i < 6; i++) tick();
    chk("r8_burst_hold", grant, 9'h100);
    rst = 1'b1;
    #2;
    chk("mid_rst_grant", grant, 9'h001);
    chk("mid_rst_master", master, 4'd0);
    chk("mid_rst_lock", mlock, 1'b0);
    #2;
    rst = 1'b0;
    // BUSY holds the counter: regrant here shows it was cleared by reset
    trans = BUSY;
    tick(); chk("post_rst_grant", grant, 9'h100);
    chk("post_rst_master", master, 4'd0);
    trans = NONSEQ; burst = SINGLE;
    tick(); chk("post_rst_grant2", grant, 9'h100);
    chk("post_rst_master2", master, 4'd8);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
